// File: rtl/mutex_rule_scheduler_if.sv
// Handshake bundle between the guard logic, the scheduler and the rule datapath.
// The master side is the scheduler; the slave side is the guard/datapath environment.
interface mutex_rule_scheduler_if #(
  parameter int NODES     = 3,
  parameter int NUM_RULES = 12,
  parameter int IDX_W     = 4
);
  logic                 sched_en;
  logic [NUM_RULES-1:0] guard;
  logic                 fire_ready;
  logic [IDX_W-1:0]     io_en_a;
  logic                 fire_valid;
  logic [NODES-1:0]     starved;
  logic                 deadlock;
  logic [15:0]          fire_count;

  modport master (
    input  sched_en, guard, fire_ready,
    output io_en_a, fire_valid, starved, deadlock, fire_count
  );

  modport slave (
    output sched_en, guard, fire_ready,
    input  io_en_a, fire_valid, starved, deadlock, fire_count
  );
endinterface

// File: rtl/mutex_rule_scheduler.sv
// Chooses one guarded rule per step: starved nodes first, otherwise round-robin.
// Also detects a run of empty selection cycles and reports it as a sticky deadlock.
module mutex_rule_scheduler #(
  parameter int NODES          = 3,
  parameter int RULES_PER_NODE = 4,
  parameter int NUM_RULES      = 12,
  parameter int IDX_W          = 4,
  parameter int STARVE_LIMIT   = 7,
  parameter int CNT_W          = 3,
  parameter int DEADLOCK_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  mutex_rule_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DEADLOCK} state_t;

  localparam logic [IDX_W-1:0] NOP     = '1;
  localparam int               EMPTY_W = $clog2(DEADLOCK_LIMIT + 1);

  state_t               state, next_state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_RULES-1:0] sel_guard;
  logic [CNT_W-1:0]     starve_cnt [NODES];
  logic [EMPTY_W-1:0]   empty_cnt;
  logic                 deadlock_q;
  logic [15:0]          fire_count_q;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 any_guard;
  logic                 handshake;
  logic [NODES-1:0]     starved_vec;

  assign any_guard = |bus.guard;
  assign handshake = (state == ISSUE) && bus.fire_ready;

  always_comb begin
    starved_vec = '0;
    for (int n = 0; n < NODES; n++)
      starved_vec[n] = (starve_cnt[n] == CNT_W'(STARVE_LIMIT));
  end

  // Starved nodes with a live guard pre-empt the round-robin scan.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      for (int k = 0; k < RULES_PER_NODE; k++) begin
        if (!pick_found && starved_vec[n] && bus.guard[n*RULES_PER_NODE + k]) begin
          pick_idx   = IDX_W'(n*RULES_PER_NODE + k);
          pick_found = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_RULES; k++) begin
      int cand;
      cand = (int'(rr_ptr) + k) % NUM_RULES;
      if (!pick_found && bus.guard[cand]) begin
        pick_idx   = IDX_W'(cand);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.sched_en) next_state = SELECT;
      SELECT: begin
        if (!bus.sched_en)                                  next_state = IDLE;
        else if (any_guard)                                 next_state = ISSUE;
        else if (empty_cnt == EMPTY_W'(DEADLOCK_LIMIT - 1)) next_state = DEADLOCK;
      end
      ISSUE:    if (bus.fire_ready) next_state = bus.sched_en ? SELECT : IDLE;
      DEADLOCK: if (!bus.sched_en) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      sel_idx      <= NOP;
      sel_guard    <= '0;
      empty_cnt    <= '0;
      deadlock_q   <= 1'b0;
      fire_count_q <= '0;
      for (int n = 0; n < NODES; n++) starve_cnt[n] <= '0;
    end else begin
      if (state == SELECT && next_state == ISSUE) begin
        sel_idx   <= pick_idx;
        sel_guard <= bus.guard;
      end
      if (state == SELECT && next_state == SELECT && !any_guard)
        empty_cnt <= empty_cnt + 1'b1;
      else
        empty_cnt <= '0;
      if (next_state == DEADLOCK && state != DEADLOCK) deadlock_q <= 1'b1;
      else if (next_state == IDLE)                     deadlock_q <= 1'b0;
      // Losers are judged on the guards seen when the winner was chosen.
      if (handshake) begin
        rr_ptr       <= (sel_idx == IDX_W'(NUM_RULES - 1)) ? '0 : sel_idx + 1'b1;
        fire_count_q <= fire_count_q + 16'd1;
        for (int n = 0; n < NODES; n++) begin
          if (n == int'(sel_idx) / RULES_PER_NODE)
            starve_cnt[n] <= '0;
          else if ((|sel_guard[n*RULES_PER_NODE +: RULES_PER_NODE]) && !starved_vec[n])
            starve_cnt[n] <= starve_cnt[n] + 1'b1;
        end
      end
    end
  end

  assign bus.fire_valid = (state == ISSUE);
  assign bus.io_en_a    = (state == ISSUE) ? sel_idx : NOP;
  assign bus.starved    = starved_vec;
  assign bus.deadlock   = deadlock_q;
  assign bus.fire_count = fire_count_q;

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Directed bench for mutex_rule_scheduler: a vector table for round-robin, wrap and
// backpressure, then hand-written sequences for reset, deadlock and starvation.
module tb_mutex_rule_scheduler;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mutex_rule_scheduler_if #(.NODES(3), .NUM_RULES(12), .IDX_W(4)) bus ();

  mutex_rule_scheduler #(
    .NODES(3), .RULES_PER_NODE(4), .NUM_RULES(12), .IDX_W(4),
    .STARVE_LIMIT(7), .CNT_W(3), .DEADLOCK_LIMIT(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sched_en;
    logic [11:0] guard;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_idx;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [26];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic apply_stimulus(input logic sched_en, input logic [11:0] guard,
                                input logic ready);
    bus.sched_en   = sched_en;
    bus.guard      = guard;
    bus.fire_ready = ready;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.sched_en   = 1'b0;
    bus.guard      = '0;
    bus.fire_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    vecs[0]  = '{1'b1, 12'h000, 1'b0, 1'b0, 4'hF, 16'd0};
    vecs[1]  = '{1'b1, 12'h00C, 1'b1, 1'b1, 4'h2, 16'd0};
    vecs[2]  = '{1'b1, 12'h00C, 1'b1, 1'b0, 4'hF, 16'd1};
    vecs[3]  = '{1'b1, 12'h00C, 1'b1, 1'b1, 4'h3, 16'd1};
    vecs[4]  = '{1'b1, 12'h00C, 1'b1, 1'b0, 4'hF, 16'd2};
    vecs[5]  = '{1'b1, 12'h00C, 1'b1, 1'b1, 4'h2, 16'd2};
    vecs[6]  = '{1'b1, 12'h00C, 1'b1, 1'b0, 4'hF, 16'd3};
    vecs[7]  = '{1'b1, 12'h00C, 1'b1, 1'b1, 4'h3, 16'd3};
    vecs[8]  = '{1'b1, 12'h00C, 1'b1, 1'b0, 4'hF, 16'd4};
    vecs[9]  = '{1'b1, 12'h400, 1'b1, 1'b1, 4'hA, 16'd4};
    vecs[10] = '{1'b1, 12'h400, 1'b1, 1'b0, 4'hF, 16'd5};
    vecs[11] = '{1'b1, 12'h801, 1'b1, 1'b1, 4'hB, 16'd5};
    vecs[12] = '{1'b1, 12'h801, 1'b1, 1'b0, 4'hF, 16'd6};
    vecs[13] = '{1'b1, 12'h801, 1'b1, 1'b1, 4'h0, 16'd6};
    vecs[14] = '{1'b1, 12'h801, 1'b1, 1'b0, 4'hF, 16'd7};
    vecs[15] = '{1'b1, 12'h003, 1'b1, 1'b1, 4'h1, 16'd7};
    vecs[16] = '{1'b1, 12'h003, 1'b1, 1'b0, 4'hF, 16'd8};
    vecs[17] = '{1'b1, 12'h00C, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[18] = '{1'b1, 12'h008, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[19] = '{1'b1, 12'h004, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[20] = '{1'b1, 12'hFFF, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[21] = '{1'b1, 12'h000, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[22] = '{1'b1, 12'h008, 1'b0, 1'b1, 4'h2, 16'd8};
    vecs[23] = '{1'b1, 12'h008, 1'b1, 1'b0, 4'hF, 16'd9};
    vecs[24] = '{1'b1, 12'h000, 1'b1, 1'b0, 4'hF, 16'd9};
    vecs[25] = '{1'b0, 12'h000, 1'b1, 1'b0, 4'hF, 16'd9};

    reset_n        = 1'b0;
    bus.sched_en   = 1'b0;
    bus.guard      = '0;
    bus.fire_ready = 1'b0;
    #3;
    check_output("reset_valid",    32'(bus.fire_valid), 32'd0);
    check_output("reset_idx",      32'(bus.io_en_a),    32'hF);
    check_output("reset_count",    32'(bus.fire_count), 32'd0);
    check_output("reset_starved",  32'(bus.starved),    32'd0);
    check_output("reset_deadlock", 32'(bus.deadlock),   32'd0);
    do_reset();

    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].sched_en, vecs[i].guard, vecs[i].ready);
      check_output($sformatf("v%0d_valid", i), 32'(bus.fire_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("v%0d_idx", i),   32'(bus.io_en_a),    32'(vecs[i].exp_idx));
      check_output($sformatf("v%0d_count", i), 32'(bus.fire_count), 32'(vecs[i].exp_count));
    end

    // Asynchronous reset while a rule is being presented.
    apply_stimulus(1'b1, 12'h001, 1'b0);
    apply_stimulus(1'b1, 12'h001, 1'b0);
    check_output("t1_pre_valid", 32'(bus.fire_valid), 32'd1);
    check_output("t1_pre_idx",   32'(bus.io_en_a),    32'd0);
    reset_n = 1'b0;
    #1;
    check_output("t1_valid", 32'(bus.fire_valid), 32'd0);
    check_output("t1_idx",   32'(bus.io_en_a),    32'hF);
    check_output("t1_count", 32'(bus.fire_count), 32'd0);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 12'h000, 1'b0);
      check_output($sformatf("t6_deadlock_%0d", i), 32'(bus.deadlock), 32'(i == 4));
      check_output($sformatf("t6_valid_%0d", i),    32'(bus.fire_valid), 32'd0);
    end
    apply_stimulus(1'b1, 12'h000, 1'b0);
    check_output("t6_sticky", 32'(bus.deadlock), 32'd1);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("t6_cleared", 32'(bus.deadlock), 32'd0);

    do_reset();
    apply_stimulus(1'b1, 12'h000, 1'b0);
    apply_stimulus(1'b1, 12'h004, 1'b1);
    check_output("t5_first_idx", 32'(bus.io_en_a), 32'd2);
    apply_stimulus(1'b1, 12'h004, 1'b1);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, 12'hFF2, 1'b1);
      check_output($sformatf("t5_idx_%0d", i), 32'(bus.io_en_a), 32'(4 + i));
      apply_stimulus(1'b1, 12'hFF2, 1'b1);
      check_output($sformatf("t5_starved_%0d", i), 32'(bus.starved), (i == 6) ? 32'd1 : 32'd0);
    end
    apply_stimulus(1'b1, 12'hFF2, 1'b1);
    check_output("t5_priority_idx", 32'(bus.io_en_a), 32'd1);
    apply_stimulus(1'b1, 12'hFF2, 1'b1);
    check_output("t5_starved_clear", 32'(bus.starved),    32'd0);
    check_output("t5_count",         32'(bus.fire_count), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
